// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory port arbiter.
// The arbiter uses the master view; the surrounding pipeline/memory uses the slave view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  logic [1:0]  owner;
  logic        err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_wstrb, m_addr, m_wdata,
    output owner, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_wstrb, m_addr, m_wdata,
    input  owner, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the data stage,
// sequences the memory handshake and returns data/ack (with timeout error) to the winner.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_I      = 2'd1;
  localparam logic [1:0] OWN_D      = 2'd2;

  state_t      state_r, state_s;
  logic [3:0]  streak_r, streak_s;
  logic [7:0]  tmo_r, tmo_s;
  logic        m_req_r, m_req_s;
  logic        m_we_r, m_we_s;
  logic [3:0]  m_wstrb_r, m_wstrb_s;
  logic [31:0] m_addr_r, m_addr_s;
  logic [31:0] m_wdata_r, m_wdata_s;
  logic [31:0] i_rdata_r, i_rdata_s;
  logic        i_ack_r, i_ack_s;
  logic [31:0] d_rdata_r, d_rdata_s;
  logic        d_ack_r, d_ack_s;
  logic [1:0]  owner_r, owner_s;
  logic        err_r, err_s;
  logic        fetch_win_s;
  logic [31:0] resp_data_s;

  // Fetch wins when it is alone or when data has used up its streak allowance.
  assign fetch_win_s = bus.i_req && (!bus.d_req || (streak_r == STREAK_MAX));
  // A timed-out transaction returns zero data.
  assign resp_data_s = bus.m_ack ? bus.m_rdata : 32'd0;

  // Next-state and next-output logic of the arbitration/handshake FSM.
  always_comb begin
    state_s   = state_r;
    streak_s  = streak_r;
    tmo_s     = tmo_r;
    m_req_s   = m_req_r;
    m_we_s    = m_we_r;
    m_wstrb_s = m_wstrb_r;
    m_addr_s  = m_addr_r;
    m_wdata_s = m_wdata_r;
    i_rdata_s = i_rdata_r;
    i_ack_s   = i_ack_r;
    d_rdata_s = d_rdata_r;
    d_ack_s   = d_ack_r;
    owner_s   = owner_r;
    err_s     = err_r;
    case (state_r)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_s = BUSY;
          m_req_s = 1'b1;
          tmo_s   = 8'd0;
          if (fetch_win_s) begin
            owner_s   = OWN_I;
            streak_s  = 4'd0;
            m_we_s    = 1'b0;
            m_wstrb_s = 4'b0000;
            m_addr_s  = bus.i_addr;
            m_wdata_s = 32'd0;
          end else begin
            owner_s   = OWN_D;
            m_we_s    = bus.d_we;
            m_wstrb_s = bus.d_wstrb;
            m_addr_s  = bus.d_addr;
            m_wdata_s = bus.d_wdata;
            if (!bus.i_req) begin
              streak_s = 4'd0;
            end else if (streak_r != STREAK_MAX) begin
              streak_s = streak_r + 4'd1;
            end else begin
              streak_s = streak_r;
            end
          end
        end else begin
          m_req_s = 1'b0;
        end
      end
      BUSY: begin
        tmo_s = tmo_r + 8'd1;
        if (bus.m_ack || (tmo_r == TMO_LAST)) begin
          state_s = RESP;
          m_req_s = 1'b0;
          m_we_s  = 1'b0;
          err_s   = !bus.m_ack;
          if (owner_r == OWN_I) begin
            i_ack_s   = 1'b1;
            i_rdata_s = resp_data_s;
          end else begin
            d_ack_s   = 1'b1;
            d_rdata_s = resp_data_s;
          end
        end else begin
          m_req_s = 1'b1;
        end
      end
      RESP: begin
        state_s = IDLE;
        i_ack_s = 1'b0;
        d_ack_s = 1'b0;
        err_s   = 1'b0;
        owner_s = OWN_NONE;
        tmo_s   = 8'd0;
      end
      default: begin
        state_s = IDLE;
        m_req_s = 1'b0;
        m_we_s  = 1'b0;
        i_ack_s = 1'b0;
        d_ack_s = 1'b0;
        err_s   = 1'b0;
        owner_s = OWN_NONE;
        tmo_s   = 8'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      streak_r  <= 4'd0;
      tmo_r     <= 8'd0;
      m_req_r   <= 1'b0;
      m_we_r    <= 1'b0;
      m_wstrb_r <= 4'b0000;
      m_addr_r  <= 32'd0;
      m_wdata_r <= 32'd0;
      i_rdata_r <= 32'd0;
      i_ack_r   <= 1'b0;
      d_rdata_r <= 32'd0;
      d_ack_r   <= 1'b0;
      owner_r   <= OWN_NONE;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      streak_r  <= streak_s;
      tmo_r     <= tmo_s;
      m_req_r   <= m_req_s;
      m_we_r    <= m_we_s;
      m_wstrb_r <= m_wstrb_s;
      m_addr_r  <= m_addr_s;
      m_wdata_r <= m_wdata_s;
      i_rdata_r <= i_rdata_s;
      i_ack_r   <= i_ack_s;
      d_rdata_r <= d_rdata_s;
      d_ack_r   <= d_ack_s;
      owner_r   <= owner_s;
      err_r     <= err_s;
    end
  end

  assign bus.m_req   = m_req_r;
  assign bus.m_we    = m_we_r;
  assign bus.m_wstrb = m_wstrb_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;
  assign bus.i_rdata = i_rdata_r;
  assign bus.i_ack   = i_ack_r;
  assign bus.d_rdata = d_rdata_r;
  assign bus.d_ack   = d_ack_r;
  assign bus.owner   = owner_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester/memory agents plus a cycle-level
// reference model of the arbitration rules, with a few directed scenarios.
module tb_mem_port_arbiter;
  localparam int MAXS  = 4;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // stimulus knobs
  int          p_i = 0, p_d = 0, mem_mode = 0;
  bit          spur_en = 1'b0, mem_fix_en = 1'b0, log_en = 1'b0;
  logic [31:0] mem_fix_val = 32'd0;
  bit          inj_i = 1'b0, inj_d = 1'b0;
  logic [31:0] inj_i_addr, inj_d_addr, inj_d_wdata;
  logic        inj_d_we;
  logic [3:0]  inj_d_wstrb;

  // memory agent
  int mem_cnt = 0, mem_w = 0;
  bit mem_prev = 1'b0;

  // reference model: who holds the port, how long memory has been waited on,
  // whether the next cycle carries the completion pulse, and the data streak
  int          own = 0, waited = 0, streak = 0;
  bit          acking = 1'b0;
  logic        exp_mreq, exp_iack, exp_dack, exp_err;
  logic [1:0]  exp_owner;
  logic [31:0] exp_rdata;
  logic [31:0] g_addr, g_wdata;
  logic        g_we;
  logic [3:0]  g_wstrb;

  bit prev_mreq = 1'b0;
  int obs_grants[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // expected outputs for the next cycle, from the inputs now applied
  task automatic predict();
    exp_iack = 1'b0;
    exp_dack = 1'b0;
    exp_err  = 1'b0;
    if (acking) begin
      acking    = 1'b0;
      own       = 0;
      exp_mreq  = 1'b0;
      exp_owner = 2'd0;
    end else if (own == 0) begin
      if (bus.i_req || bus.d_req) begin
        if (bus.i_req && (!bus.d_req || streak == MAXS)) begin
          own = 1; streak = 0;
          g_addr = bus.i_addr; g_we = 1'b0; g_wstrb = 4'b0000; g_wdata = 32'd0;
        end else begin
          own = 2;
          if (!bus.i_req) streak = 0;
          else if (streak < MAXS) streak++;
          g_addr = bus.d_addr; g_we = bus.d_we; g_wstrb = bus.d_wstrb; g_wdata = bus.d_wdata;
        end
        waited    = 0;
        exp_mreq  = 1'b1;
        exp_owner = 2'(own);
      end else begin
        exp_mreq  = 1'b0;
        exp_owner = 2'd0;
      end
    end else if (bus.m_ack || waited == TMO - 1) begin
      acking    = 1'b1;
      exp_mreq  = 1'b0;
      exp_owner = 2'(own);
      exp_err   = !bus.m_ack;
      exp_rdata = bus.m_ack ? bus.m_rdata : 32'd0;
      if (own == 1) exp_iack = 1'b1;
      else exp_dack = 1'b1;
    end else begin
      waited++;
      exp_mreq  = 1'b1;
      exp_owner = 2'(own);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_val("m_req", bus.m_req, exp_mreq);
    check_val("owner", bus.owner, exp_owner);
    check_val("i_ack", bus.i_ack, exp_iack);
    check_val("d_ack", bus.d_ack, exp_dack);
    check_val("err", bus.err, exp_err);
    if (exp_iack) check_val("i_rdata", bus.i_rdata, exp_rdata);
    if (exp_dack) check_val("d_rdata", bus.d_rdata, exp_rdata);
    if (exp_mreq) begin
      check_val("m_addr", bus.m_addr, g_addr);
      check_val("m_we", bus.m_we, g_we);
      check_val("m_wstrb", bus.m_wstrb, g_wstrb);
      check_val("m_wdata", bus.m_wdata, g_wdata);
    end else begin
      check_val("m_we_idle", bus.m_we, 1'b0);
    end
    if (log_en && bus.m_req && !prev_mreq) obs_grants.push_back(int'(bus.owner));
    prev_mreq = bus.m_req;

    // requesters drop on ack and may re-request at once
    if (bus.i_ack) bus.i_req = 1'b0;
    if (bus.d_ack) bus.d_req = 1'b0;
    if (!bus.i_req) begin
      if (inj_i) begin
        bus.i_req = 1'b1; bus.i_addr = inj_i_addr; inj_i = 1'b0;
      end else if ($urandom_range(99) < p_i) begin
        bus.i_req = 1'b1; bus.i_addr = $urandom & 32'hFFFF_FFFC;
      end
    end
    if (!bus.d_req) begin
      if (inj_d) begin
        bus.d_req = 1'b1; bus.d_we = inj_d_we; bus.d_wstrb = inj_d_wstrb;
        bus.d_addr = inj_d_addr; bus.d_wdata = inj_d_wdata; inj_d = 1'b0;
      end else if ($urandom_range(99) < p_d) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom); bus.d_wstrb = 4'($urandom);
        bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
    end

    // memory agent
    if (bus.m_req) begin
      if (!mem_prev) begin
        mem_cnt = 0;
        case (mem_mode)
          1: mem_w = 0;
          2: mem_w = 3;
          3: mem_w = NEVER;
          4: mem_w = 5;
          default: mem_w = ($urandom_range(9) == 0) ? NEVER : int'($urandom_range(3));
        endcase
      end else begin
        mem_cnt++;
      end
      bus.m_ack   = (mem_cnt == mem_w);
      bus.m_rdata = mem_fix_en ? mem_fix_val : $urandom;
    end else begin
      bus.m_ack   = spur_en && ($urandom_range(5) == 0);
      bus.m_rdata = $urandom;
    end
    mem_prev = bus.m_req;
    predict();
  endtask

  task automatic drain();
    p_i = 0;
    p_d = 0;
    for (int k = 0; k < 24; k++) step();
  endtask

  initial begin
    int exp_pat[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    bit reached;
    bus.i_req = 1'b0; bus.i_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = 4'd0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
    bus.m_ack = 1'b0; bus.m_rdata = 32'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_m_req", bus.m_req, 1'b0);
    check_val("rst_m_we", bus.m_we, 1'b0);
    check_val("rst_m_wstrb", bus.m_wstrb, 4'd0);
    check_val("rst_m_addr", bus.m_addr, 32'd0);
    check_val("rst_m_wdata", bus.m_wdata, 32'd0);
    check_val("rst_i_ack", bus.i_ack, 1'b0);
    check_val("rst_d_ack", bus.d_ack, 1'b0);
    check_val("rst_i_rdata", bus.i_rdata, 32'd0);
    check_val("rst_d_rdata", bus.d_rdata, 32'd0);
    check_val("rst_owner", bus.owner, 2'd0);
    check_val("rst_err", bus.err, 1'b0);
    rst = 1'b0;
    predict();

    // single zero-wait fetch
    mem_mode = 1; mem_fix_en = 1'b1; mem_fix_val = 32'h0000_0013;
    inj_i = 1'b1; inj_i_addr = 32'h44;
    drain();
    mem_fix_en = 1'b0;

    // simultaneous fetch and load: data first, fetch next
    mem_mode = 0;
    inj_i = 1'b1; inj_i_addr = 32'h100;
    inj_d = 1'b1; inj_d_we = 1'b0; inj_d_wstrb = 4'b0000; inj_d_addr = 32'h2000; inj_d_wdata = 32'd0;
    drain();

    // continuous contention: streak limit
    obs_grants.delete();
    log_en = 1'b1; p_i = 100; p_d = 100; mem_mode = 1;
    for (int k = 0; k < 200 && obs_grants.size() < 10; k++) step();
    log_en = 1'b0;
    check_val("grant_cnt", 32'(obs_grants.size() >= 10), 32'd1);
    for (int k = 0; k < 10; k++) check_val("grant_order", 32'(obs_grants[k]), 32'(exp_pat[k]));
    drain();

    // store with 3 wait states
    mem_mode = 2;
    inj_d = 1'b1; inj_d_we = 1'b1; inj_d_wstrb = 4'b0011; inj_d_addr = 32'h2002; inj_d_wdata = 32'hBEEF;
    drain();

    // memory never acks: timeout
    mem_mode = 3;
    inj_d = 1'b1; inj_d_we = 1'b0; inj_d_wstrb = 4'b0000; inj_d_addr = 32'h3000; inj_d_wdata = 32'd0;
    drain();

    // reset in the middle of a data transaction
    mem_mode = 4;
    inj_d = 1'b1; inj_d_we = 1'b0; inj_d_wstrb = 4'b0000; inj_d_addr = 32'h4000; inj_d_wdata = 32'd0;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      step();
      if (own == 2 && waited == 2 && !acking) reached = 1'b1;
    end
    check_val("rst_setup", 32'(reached), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("arst_m_req", bus.m_req, 1'b0);
    check_val("arst_d_ack", bus.d_ack, 1'b0);
    check_val("arst_owner", bus.owner, 2'd0);
    own = 0; acking = 1'b0; streak = 0; waited = 0;
    mem_prev = 1'b0; prev_mreq = 1'b0; bus.m_ack = 1'b0;
    @(posedge clk);
    #1;
    check_val("arst_hold_m_req", bus.m_req, 1'b0);
    check_val("arst_hold_d_ack", bus.d_ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    predict();
    drain();

    // randomized traffic with spurious memory acks
    spur_en = 1'b1; mem_mode = 0;
    for (int blk = 0; blk < 8; blk++) begin
      p_i = int'($urandom_range(80, 10));
      p_d = int'($urandom_range(80, 10));
      for (int k = 0; k < 100; k++) step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage: loads/stores such as lh/sh). It grants one requester at a time and sequences the memory handshake. It routes read data and acknowledge back to the winner and flags memory timeouts. It sits between the pipeline stages and the memory module inside the core.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win (1..15)
TIMEOUT, 64, cycles in BUSY without m_ack before the transaction is aborted with error (2..255)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
i_req  input  1  fetch request; held with i_addr stable until i_ack
i_addr  input  32  fetch word address
i_rdata  output  32  fetch read data, valid while i_ack=1
i_ack  output  1  one-cycle fetch completion pulse
d_req  input  1  data request; held with d_* stable until d_ack
d_we  input  1  1=store, 0=load
d_wstrb  input  4  byte enables for stores
d_addr  input  32  data address
d_wdata  input  32  store data
d_rdata  output  32  load data, valid while d_ack=1
d_ack  output  1  one-cycle data completion pulse
m_req  output  1  memory request, held until m_ack or timeout
m_we  output  1  memory write enable
m_wstrb  output  4  memory byte enables
m_addr  output  32  memory address
m_wdata  output  32  memory write data
m_rdata  input  32  memory read data, valid with m_ack
m_ack  input  1  memory completion; may be asserted the cycle m_req first rises
owner  output  2  0=none, 1=fetch, 2=data (current BUSY/RESP owner)
err  output  1  asserted with i_ack/d_ack when the transaction timed out

Behaviour:
- All outputs registered. Reset: state IDLE; m_req, m_we, m_wstrb, m_addr, m_wdata, i_ack, d_ack, err=0; i_rdata, d_rdata=0; owner=0; streak and timeout counters=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE, neither request: stay; outputs quiescent (m_req=0).
- IDLE with request(s): select winner. Load m_* from the winner (fetch: m_we=0, m_wstrb=0, m_wdata=0), set m_req=1, set owner, go to BUSY.
- Priority: data wins by default. Fetch wins if only i_req is high, or if i_req is high and streak==MAX_D_STREAK.
- Streak counter updates at grant time:
  - data grant with i_req high: increment, saturating at MAX_D_STREAK;
  - data grant with i_req low: clear;
  - fetch grant: clear.
- BUSY: timeout counter increments each cycle.
  - m_ack=1: capture m_rdata into the owner's rdata; pulse the owner's ack; clear m_req and m_we; go to RESP.
  - Counter reaches TIMEOUT-1 without m_ack: same path to RESP, but rdata=0 and err=1.
  - The non-owner's request is ignored while BUSY.
- RESP (exactly one cycle): ack/err high. Next edge: clear ack, err, owner and timeout counter; go to IDLE.
  - Requester contract: drop req at the edge where it samples ack=1.
  - Requests are not re-evaluated until IDLE, so a back-to-back request from the same requester is granted no earlier than the IDLE cycle that follows RESP.
- Latency with zero-wait memory (m_ack same cycle as m_req): request seen in IDLE at cycle 0; ack high in cycle 2; next grant decision in cycle 3. A transaction occupies 3 cycles plus memory wait states.
- Address and data are passed through unmodified; alignment and sub-word extraction for lh/lb are the MEM stage's job.
- Simultaneous i_req and d_req in IDLE: exactly one is granted. The loser stays pending and is evaluated at the next IDLE.
- Reset mid-transaction: the transaction is abandoned immediately and all outputs go to reset values asynchronously. No ack is issued for the in-flight request.
- A spurious m_ack in IDLE or RESP is ignored.

Test Plan:
- Reset during BUSY (d_req, memory with 5 wait states, rst at wait 2) -> m_req, d_ack, owner drop to 0 asynchronously; after release, d_req still high -> fresh data grant.
- Single fetch, i_addr=0x44, zero-wait memory returning 0x00000013 -> m_req=1, m_addr=0x44 in cycle 1; i_ack=1, i_rdata=0x13, err=0 in cycle 2; owner back to 0 in cycle 3.
- Simultaneous i_req (0x100) and d_req load (0x2000) -> data granted first (owner=2, m_addr=0x2000); fetch granted at the next IDLE, m_addr=0x100.
- Continuous d_req with i_req held high, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; streak clears after each I.
- Store d_we=1, d_wstrb=4'b0011, d_addr=0x2002, d_wdata=0xBEEF, 3 wait states -> m_we=1, m_wstrb=0011, m_wdata=0xBEEF held for 4 cycles; d_ack 1 cycle after m_ack.
- Memory never acks, TIMEOUT=8 -> m_req high exactly 8 cycles, then d_ack=1, err=1, d_rdata=0 for one cycle; arbiter returns to IDLE.
